mem_port_arbiter: RTL and testbench

Two-master arbiter and sequencer that shares the single-ported instruction/data memory (16-bit-halved BRAM, word/half-word access with sign-extension control) between the instruction-fetch unit and the load/store unit. Latches one request at a time, drives the memory strobe for exactly one access cycle, then returns the read data and a one-cycle ack to the winning master. Data accesses have priority; a streak counter guarantees fetch progress.

---
 rtl/mem_arb_pkg.sv | 35 +++
 rtl/mem_arb_pick.sv | 53 +++++
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, master IDs and the
// latched request record.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    localparam logic MST_I = 1'b0;
    localparam logic MST_D = 1'b1;

    // Address field width of the request record; the top supports ADDR_W up to this.
    localparam int REQ_ADR_W = 32;

    typedef struct packed {
        logic                 we;
        logic                 half_w;
        logic                 signext;
        logic [REQ_ADR_W-1:0] adr;
        logic [31:0]          dat;
        logic                 id;
    } mem_req_t;

    // Fetches are always full-word reads.
    function automatic mem_req_t make_fetch_req(input logic [REQ_ADR_W-1:0] adr);
        mem_req_t r;
        r     = '0;
        r.adr = adr;
        r.id  = MST_I;
        return r;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Two-master pick logic: data wins ties until the streak counter reaches
// STREAK_MAX, which then forces a fetch grant.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STREAK_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_stb_i,
    input  logic       d_stb_i,
    input  logic [1:0] excl_i,
    input  logic       take_i,
    output logic       gnt_vld_o,
    output logic       gnt_id_o
);

    localparam logic [3:0] STREAK_LIM = 4'(STREAK_MAX);

    logic [3:0] streak_q;
    logic [3:0] streak_d;
    logic       i_req;
    logic       d_req;

    always_comb begin
        i_req     = i_stb_i & ~excl_i[MST_I];
        d_req     = d_stb_i & ~excl_i[MST_D];
        gnt_vld_o = i_req | d_req;
        gnt_id_o  = MST_I;
        if (d_req && (!i_req || streak_q != STREAK_LIM)) begin
            gnt_id_o = MST_D;
        end

        // Streak only counts data grants that made a raised fetch request wait.
        streak_d = streak_q;
        if (take_i && gnt_vld_o) begin
            if (gnt_id_o == MST_I || !i_stb_i) begin
                streak_d = '0;
            end else if (streak_q != STREAK_LIM) begin
                streak_d = streak_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store: latch a
// request, strobe memory for one cycle, then ack the winner with read data.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STREAK_MAX = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_stb_i,
    input  logic [ADDR_W-1:0] i_adr_i,
    output logic [31:0]       i_dat_o,
    output logic              i_ack_o,
    input  logic              d_stb_i,
    input  logic              d_we_i,
    input  logic              d_half_w_i,
    input  logic              d_signext_i,
    input  logic [ADDR_W-1:0] d_adr_i,
    input  logic [31:0]       d_dat_i,
    output logic [31:0]       d_dat_o,
    output logic              d_ack_o,
    output logic              m_stb_o,
    output logic              m_we_o,
    output logic              m_half_w_o,
    output logic              m_signext_o,
    output logic [ADDR_W-1:0] m_adr_o,
    output logic [31:0]       m_dat_o,
    input  logic [31:0]       m_dat_i
);

    arb_state_e state_q;
    arb_state_e state_d;
    mem_req_t   req_q;
    mem_req_t   req_d;
    mem_req_t   sel_req;

    logic [REQ_ADR_W-1:0] i_adr_ext;
    logic [REQ_ADR_W-1:0] d_adr_ext;
    logic [1:0]           excl;
    logic                 take;
    logic                 gnt_vld;
    logic                 gnt_id;

    mem_arb_pick #(
        .STREAK_MAX (STREAK_MAX)
    ) u_pick (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_stb_i   (i_stb_i),
        .d_stb_i   (d_stb_i),
        .excl_i    (excl),
        .take_i    (take),
        .gnt_vld_o (gnt_vld),
        .gnt_id_o  (gnt_id)
    );

    always_comb begin
        i_adr_ext             = '0;
        i_adr_ext[ADDR_W-1:0] = i_adr_i;
        d_adr_ext             = '0;
        d_adr_ext[ADDR_W-1:0] = d_adr_i;

        sel_req = make_fetch_req(i_adr_ext);
        if (gnt_id == MST_D) begin
            sel_req.we      = d_we_i;
            sel_req.half_w  = d_half_w_i;
            sel_req.signext = d_signext_i;
            sel_req.adr     = d_adr_ext;
            sel_req.dat     = d_dat_i;
            sel_req.id      = MST_D;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        take    = 1'b0;
        excl    = '0;
        unique case (state_q)
            IDLE: begin
                take = 1'b1;
                if (gnt_vld) begin
                    req_d   = sel_req;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                state_d = RESP;
            end
            RESP: begin
                // The master being acked still holds stb this cycle; keep it out.
                take           = 1'b1;
                excl[req_q.id] = 1'b1;
                if (gnt_vld) begin
                    req_d   = sel_req;
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        m_stb_o     = (state_q == ACCESS);
        m_we_o      = req_q.we;
        m_half_w_o  = req_q.half_w;
        m_signext_o = req_q.signext;
        m_adr_o     = req_q.adr[ADDR_W-1:0];
        m_dat_o     = req_q.dat;
        i_ack_o     = (state_q == RESP) && (req_q.id == MST_I);
        d_ack_o     = (state_q == RESP) && (req_q.id == MST_D);
        i_dat_o     = i_ack_o ? m_dat_i : '0;
        d_dat_o     = d_ack_o ? m_dat_i : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter: a timeline model predicts every
// memory access and ack; monitors compare what the DUT presents.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W = 32;
    localparam int SMAX   = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_stb_i = 1'b0;
    logic [ADDR_W-1:0] i_adr_i = '0;
    logic [31:0]       i_dat_o;
    logic              i_ack_o;
    logic              d_stb_i = 1'b0;
    logic              d_we_i = 1'b0;
    logic              d_half_w_i = 1'b0;
    logic              d_signext_i = 1'b0;
    logic [ADDR_W-1:0] d_adr_i = '0;
    logic [31:0]       d_dat_i = '0;
    logic [31:0]       d_dat_o;
    logic              d_ack_o;
    logic              m_stb_o;
    logic              m_we_o;
    logic              m_half_w_o;
    logic              m_signext_o;
    logic [ADDR_W-1:0] m_adr_o;
    logic [31:0]       m_dat_o;
    logic [31:0]       m_dat_i = '0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .STREAK_MAX (SMAX),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_stb_i     (i_stb_i),
        .i_adr_i     (i_adr_i),
        .i_dat_o     (i_dat_o),
        .i_ack_o     (i_ack_o),
        .d_stb_i     (d_stb_i),
        .d_we_i      (d_we_i),
        .d_half_w_i  (d_half_w_i),
        .d_signext_i (d_signext_i),
        .d_adr_i     (d_adr_i),
        .d_dat_i     (d_dat_i),
        .d_dat_o     (d_dat_o),
        .d_ack_o     (d_ack_o),
        .m_stb_o     (m_stb_o),
        .m_we_o      (m_we_o),
        .m_half_w_o  (m_half_w_o),
        .m_signext_o (m_signext_o),
        .m_adr_o     (m_adr_o),
        .m_dat_o     (m_dat_o),
        .m_dat_i     (m_dat_i)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'hA5C30000 ^ (32'(i) * 32'h00010203);
    endfunction

    // Word-organised memory: writes qualified by strobe, read data one cycle later.
    logic [31:0] mem    [0:1023];
    logic [31:0] shadow [0:1023];

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]    = init_word(i);
            shadow[i] = init_word(i);
        end
    end

    always @(posedge clk) begin
        if (m_stb_o) begin
            if (m_we_o) mem[m_adr_o[11:2]] <= m_dat_o;
            m_dat_i <= mem[m_adr_o[11:2]];
        end
    end

    typedef struct {
        int          at;
        logic        id;
        logic        chk_dat;
        logic [31:0] dat;
    } ack_exp_t;

    typedef struct {
        int          at;
        logic        we;
        logic        half_w;
        logic        signext;
        logic [31:0] adr;
        logic [31:0] dat;
    } acc_exp_t;

    ack_exp_t ack_q[$];
    acc_exp_t acc_q[$];

    // Reference model: the port is owned from grant cycle t to ack cycle t+2; a
    // new grant may be taken whenever the port is free or in the owner's ack cycle.
    int   own_until = -1;
    logic owner     = MST_I;
    int   streak_m  = 0;

    always @(posedge clk) begin
        bit       ir;
        bit       dr;
        bit       to_d;
        ack_exp_t ea;
        acc_exp_t ec;
        if (!rst_n) begin
            while (ack_q.size() > 0 && ack_q[$].at > cyc) void'(ack_q.pop_back());
            while (acc_q.size() > 0 && acc_q[$].at > cyc) void'(acc_q.pop_back());
            own_until = -1;
            streak_m  = 0;
        end else if (own_until <= cyc) begin
            ir = i_stb_i && !(own_until == cyc && owner == MST_I);
            dr = d_stb_i && !(own_until == cyc && owner == MST_D);
            if (ir || dr) begin
                to_d = dr && (!ir || streak_m < SMAX);
                if (to_d && i_stb_i) streak_m = (streak_m < SMAX) ? streak_m + 1 : SMAX;
                else                 streak_m = 0;
                ec.at = cyc + 1;
                ea.at = cyc + 2;
                ea.id = to_d ? MST_D : MST_I;
                if (to_d) begin
                    ec.we = d_we_i; ec.half_w = d_half_w_i; ec.signext = d_signext_i;
                    ec.adr = d_adr_i; ec.dat = d_dat_i;
                    ea.chk_dat = !d_we_i;
                    ea.dat = shadow[d_adr_i[11:2]];
                    if (d_we_i) shadow[d_adr_i[11:2]] = d_dat_i;
                end else begin
                    ec.we = 1'b0; ec.half_w = 1'b0; ec.signext = 1'b0;
                    ec.adr = i_adr_i; ec.dat = '0;
                    ea.chk_dat = 1'b1;
                    ea.dat = shadow[i_adr_i[11:2]];
                end
                acc_q.push_back(ec);
                ack_q.push_back(ea);
                own_until = cyc + 2;
                owner     = ea.id;
            end
        end
        cyc = cyc + 1;
    end

    // Monitor: pop and compare whenever the DUT presents an access or an ack.
    always @(negedge clk) begin
        ack_exp_t ea;
        acc_exp_t ec;
        while (ack_q.size() > 0 && ack_q[0].at < cyc) begin
            ea = ack_q.pop_front();
            checks++; errors++;
            $display("FAIL ack_missing cyc=%0d actual=none required=ack id=%0d", ea.at, ea.id);
        end
        while (acc_q.size() > 0 && acc_q[0].at < cyc) begin
            ec = acc_q.pop_front();
            checks++; errors++;
            $display("FAIL access_missing cyc=%0d actual=none required=adr %h", ec.at, ec.adr);
        end
        if (i_ack_o || d_ack_o) begin
            checks++;
            if (i_ack_o && d_ack_o) begin
                errors++;
                $display("FAIL ack_both cyc=%0d actual=i+d required=one", cyc);
            end else if (ack_q.size() == 0 || ack_q[0].at != cyc) begin
                errors++;
                $display("FAIL ack_unexpected cyc=%0d actual=i%0b d%0b required=none", cyc, i_ack_o, d_ack_o);
            end else begin
                ea = ack_q.pop_front();
                if (ea.id != d_ack_o) begin
                    errors++;
                    $display("FAIL ack_master cyc=%0d actual=%0d required=%0d", cyc, d_ack_o, ea.id);
                end else if (ea.chk_dat && (d_ack_o ? d_dat_o : i_dat_o) !== ea.dat) begin
                    errors++;
                    $display("FAIL ack_data cyc=%0d actual=%h required=%h", cyc, d_ack_o ? d_dat_o : i_dat_o, ea.dat);
                end else begin
                    $display("ack  cyc=%0d master=%s dat=%h", cyc, d_ack_o ? "D" : "I", d_ack_o ? d_dat_o : i_dat_o);
                end
            end
        end
        if (m_stb_o) begin
            checks++;
            if (acc_q.size() == 0 || acc_q[0].at != cyc) begin
                errors++;
                $display("FAIL access_unexpected cyc=%0d actual=adr %h required=none", cyc, m_adr_o);
            end else begin
                ec = acc_q.pop_front();
                if (m_adr_o !== ec.adr || m_we_o !== ec.we || m_half_w_o !== ec.half_w ||
                    m_signext_o !== ec.signext || (ec.we && m_dat_o !== ec.dat)) begin
                    errors++;
                    $display("FAIL access_fields cyc=%0d actual=adr %h we%0b hw%0b se%0b dat %h required=adr %h we%0b hw%0b se%0b dat %h",
                             cyc, m_adr_o, m_we_o, m_half_w_o, m_signext_o, m_dat_o,
                             ec.adr, ec.we, ec.half_w, ec.signext, ec.dat);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Masters: called #1 after a rising edge; hold stb through the ack cycle.
    task automatic fetch_req(input logic [31:0] adr, input int gap, output int lat, output logic [31:0] rd);
        int t0;
        t0 = cyc; lat = -1; rd = '0;
        i_adr_i = adr; i_stb_i = 1'b1;
        for (int n = 0; n < 40 && lat < 0; n++) begin
            @(negedge clk);
            if (i_ack_o) begin lat = cyc - t0; rd = i_dat_o; end
        end
        if (lat < 0) chk("fetch_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        i_stb_i = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic data_req(input logic we, input logic hw, input logic se, input logic [31:0] adr,
                            input logic [31:0] dat, input int gap, output int lat, output logic [31:0] rd);
        int t0;
        t0 = cyc; lat = -1; rd = '0;
        d_we_i = we; d_half_w_i = hw; d_signext_i = se; d_adr_i = adr; d_dat_i = dat;
        d_stb_i = 1'b1;
        for (int n = 0; n < 40 && lat < 0; n++) begin
            @(negedge clk);
            if (d_ack_o) begin lat = cyc - t0; rd = d_dat_o; end
        end
        if (lat < 0) chk("data_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        d_stb_i = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int          lat_a, lat_b, ca, cb;
        logic [31:0] rd_a, rd_b;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_i_ack", 32'(i_ack_o), 32'd0);
        chk("rst_d_ack", 32'(d_ack_o), 32'd0);
        chk("rst_m_stb", 32'(m_stb_o), 32'd0);
        chk("rst_i_dat", i_dat_o, 32'd0);
        chk("rst_d_dat", d_dat_o, 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        chk("rst_streak", 32'(dut.u_pick.streak_q), 32'd0);
        @(posedge clk); #1;

        // Isolated fetch: two-cycle latency, word from memory.
        fetch_req(32'h40, 2, lat_a, rd_a);
        chk("fetch_latency", 32'(lat_a), 32'd2);
        chk("fetch_data", rd_a, init_word(32'h40 >> 2));

        // Simultaneous fetch and data write: data first, fetch chained two cycles later.
        ca = cyc;
        fork
            fetch_req(32'h100, 0, lat_a, rd_a);
            data_req(1'b1, 1'b0, 1'b0, 32'h200, 32'hDEADBEEF, 0, lat_b, rd_b);
        join
        cb = ca;
        chk("simul_d_latency", 32'(lat_b), 32'd2);
        chk("simul_i_latency", 32'(lat_a), 32'd4);
        data_req(1'b0, 1'b0, 1'b0, 32'h200, 32'h0, 1, lat_b, rd_b);
        chk("simul_readback", rd_b, 32'hDEADBEEF);

        // Fetch held while data issues six back-to-back requests.
        fork
            fetch_req(32'h80, 1, lat_a, rd_a);
            for (int k = 0; k < 6; k++) data_req(1'b0, 1'b0, 1'b0, 32'(k * 4 + 32'h180), 32'h0, 0, lat_b, rd_b);
        join
        chk("streak_fetch_served", 32'(lat_a > 0 && lat_a <= 12), 32'd1);

        // Half-word read passes memory data through unchanged.
        data_req(1'b0, 1'b1, 1'b0, 32'h202, 32'h0, 1, lat_b, rd_b);
        chk("half_data", rd_b, 32'hDEADBEEF);

        // Reset during the ACCESS cycle of a write.
        d_we_i = 1'b1; d_half_w_i = 1'b0; d_signext_i = 1'b0;
        d_adr_i = 32'h300; d_dat_i = 32'h12345678; d_stb_i = 1'b1;
        @(posedge clk); #1;
        d_stb_i = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        chk("rstacc_m_stb", 32'(m_stb_o), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstacc_d_ack", 32'(d_ack_o), 32'd0);
        chk("rstacc_m_stb_low", 32'(m_stb_o), 32'd0);
        chk("rstacc_state", 32'(dut.state_q), 32'(IDLE));
        chk("rstacc_streak", 32'(dut.u_pick.streak_q), 32'd0);
        @(posedge clk); #1;
        data_req(1'b0, 1'b0, 1'b0, 32'h300, 32'h0, 1, lat_b, rd_b);
        chk("rstacc_readback", rd_b, 32'h12345678);

        // Data stb dropped after one cycle: ack still pulses at N+2, then idle.
        d_we_i = 1'b0; d_adr_i = 32'h204; d_stb_i = 1'b1;
        @(posedge clk); #1;
        d_stb_i = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("drop_ack", 32'(d_ack_o), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("drop_idle_ack", 32'(d_ack_o), 32'd0);
        chk("drop_idle_state", 32'(dut.state_q), 32'(IDLE));
        @(posedge clk); #1;

        // Randomised traffic from both masters.
        fork
            begin
                int lf; logic [31:0] rf;
                for (int k = 0; k < 80; k++)
                    fetch_req(32'($urandom_range(0, 1023)) << 2, $urandom_range(0, 3), lf, rf);
            end
            begin
                int ld; logic [31:0] rdd;
                logic we, hw;
                for (int k = 0; k < 80; k++) begin
                    we = 1'($urandom_range(0, 1));
                    hw = !we && 1'($urandom_range(0, 1));
                    data_req(we, hw, hw && 1'($urandom_range(0, 1)),
                             (32'($urandom_range(0, 1023)) << 2) | (hw ? 32'($urandom_range(0, 1)) << 1 : 32'd0),
                             $urandom, $urandom_range(0, 3), ld, rdd);
                end
            end
        join

        repeat (5) @(posedge clk);
        #1;
        chk("queues_drained", 32'(ack_q.size() + acc_q.size()), 32'd0);
        if (cb != ca) chk("cycle_bookkeeping", 32'(cb), 32'(ca));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
